// File: rtl/rr_burst_arbiter.sv
// N-port round-robin arbiter with burst hold, MAX_HOLD preemption and a one-cycle gap between owners.
// Optional owner lock (suppresses preemption) is enabled by defining RR_ARB_LOCK_EN.
module rr_burst_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
`ifdef RR_ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [N-1:0]      r_grant, w_grant_nxt;
  logic [ID_W-1:0]   r_id, w_id_nxt;
  logic [ID_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_timeout, w_timeout_nxt;

  logic              w_lock;
  logic              w_found;
  logic [ID_W-1:0]   w_pick;
  logic [ID_W-1:0]   w_scan_idx;
  logic              w_owner_req;
  logic              w_hold_hit;
  logic              w_expired;
  logic              w_release;

`ifdef RR_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_owner_req = req[r_id];
  assign w_hold_hit  = (r_cnt == CNT_W'(MAX_HOLD));
  assign w_expired   = w_hold_hit && !w_lock;
  assign w_release   = !w_owner_req || done || w_expired;

  // Scan from the rotating pointer; first requester found wins.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_scan_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_scan_idx = ID_W'((32'(r_ptr) + i) % N);
      if (!w_found && req[w_scan_idx]) begin
        w_found = 1'b1;
        w_pick  = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_id_nxt      = r_id;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE, GAP: begin
        if (w_found) begin
          w_state_nxt         = BUSY;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_id_nxt            = w_pick;
          w_cnt_nxt           = CNT_W'(1);
        end else begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_state_nxt   = GAP;
          w_grant_nxt   = '0;
          w_ptr_nxt     = (r_id == ID_W'(N - 1)) ? '0 : r_id + 1'b1;
          w_timeout_nxt = w_owner_req && !done && w_expired;
        end else if (!w_hold_hit) begin
          // Counter saturates at MAX_HOLD while a lock holds off preemption.
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_id      <= w_id_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_id    = r_id;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios plus random traffic against a
// behavioural owner/pointer model. Lock scenario is exercised when RR_ARB_LOCK_EN is defined.
module tb_rr_burst_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int ID_W     = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic            done = 1'b0;
  logic            lock = 1'b0;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            timeout;

  int checks = 0;
  int failures = 0;

  rr_burst_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
`ifdef RR_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: current owner (-1 = none), cycles it has held, rotation pointer, last owner.
  int              m_owner = -1;
  int              m_len = 0;
  int              m_ptr = 0;
  int              m_last = 0;
  logic [N-1:0]    e_grant = '0;
  logic            e_valid = 1'b0;
  logic [ID_W-1:0] e_id = '0;
  logic            e_to = 1'b0;

  task automatic model_update();
    bit expired;
    e_to = 1'b0;
    if (rst) begin
      m_owner = -1; m_len = 0; m_ptr = 0; m_last = 0;
    end else if (m_owner >= 0) begin
      expired = (m_len >= MAX_HOLD) && !lock;
      if (!req[m_owner] || done || expired) begin
        e_to    = req[m_owner] && !done && expired;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_len++;
      end
    end else begin
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_len   = 1;
          m_last  = m_owner;
        end
    end
    e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e_valid = (m_owner >= 0);
    e_id    = ID_W'(m_last);
  endtask

  // Advance one clock: model follows the edge, outputs are then sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; done = 1'b0; lock = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 1'b1;
    step(); step();
    checks++;
    if (grant !== '0 || grant_valid !== 1'b0 || grant_id !== '0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset grant=%b valid=%b id=%0d to=%b required 0000/0/0/0", grant, grant_valid, grant_id, timeout);
    end
    rst = 1'b0; req = '0; done = 1'b0;
  endtask

  task automatic test_single_owner();
    apply_reset();
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency grant=%b id=%0d valid=%b required 0100/2/1", grant, grant_id, grant_valid);
    end
    step(); step();
    req = 4'b0000;
    step();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd2 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL single_release grant=%b valid=%b id=%0d to=%b required 0000/0/2/0", grant, grant_valid, grant_id, timeout);
    end
    req = 4'b1111;
    step();
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL single_ptr grant=%b required 1000", grant);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] seen[$];
    logic [N-1:0] want[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] prev;
    apply_reset();
    req = 4'b1111;
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      done = (m_owner >= 0 && m_len == 3);
      step();
      checks++;
      if (grant !== e_grant || grant_valid !== e_valid || grant_id !== e_id || timeout !== e_to) begin
        failures++;
        $display("FAIL rotation c=%0d grant=%b/%b valid=%b/%b id=%0d/%0d to=%b/%b (got/required)",
                 c, grant, e_grant, grant_valid, e_valid, grant_id, e_id, timeout, e_to);
      end
      if (grant !== '0 && grant !== prev) seen.push_back(grant);
      prev = grant;
    end
    done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= seen.size() || seen[i] !== want[i]) begin
        failures++;
        $display("FAIL rotation_order i=%0d got=%b required %b", i, (i < seen.size()) ? seen[i] : 4'bxxxx, want[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int high = 0;
    int pulses = 0;
    apply_reset();
    req = 4'b0011;
    for (int c = 0; c < 11; c++) begin
      step();
      if (grant === 4'b0001) high++;
      if (timeout === 1'b1) begin
        pulses++;
        checks++;
        if (grant !== '0 || c != MAX_HOLD) begin
          failures++;
          $display("FAIL timeout_pulse c=%0d grant=%b required c=%0d grant=0000", c, grant, MAX_HOLD);
        end
      end
    end
    checks++;
    if (high != MAX_HOLD || pulses != 1 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL timeout_burst high=%0d pulses=%0d grant=%b required %0d/1/0010", high, pulses, grant, MAX_HOLD);
    end
  endtask

  task automatic test_limit_coincide();
    apply_reset();
    req = 4'b0001;
    for (int c = 0; c < MAX_HOLD; c++) step();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (grant !== '0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL limit_done grant=%b to=%b required 0000/0", grant, timeout);
    end
    for (int c = 0; c < MAX_HOLD; c++) step();
    req = 4'b0000;
    step();
    checks++;
    if (grant !== '0 || timeout !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL limit_reqdrop grant=%b to=%b id=%0d required 0000/0/0", grant, timeout, grant_id);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req = 4'b0100;
    step(); step();
    rst = 1'b1;
    step();
    checks++;
    if (grant !== '0 || timeout !== 1'b0 || grant_id !== '0) begin
      failures++;
      $display("FAIL midreset grant=%b to=%b id=%0d required 0000/0/0", grant, timeout, grant_id);
    end
    rst = 1'b0; req = 4'b1111;
    step();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_first grant=%b required 0001", grant);
    end
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    lock = 1'b1; req = 4'b0010;
    for (int c = 0; c < MAX_HOLD + 4; c++) begin
      step();
      checks++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL lock_hold c=%0d grant=%b to=%b required 0010/0", c, grant, timeout);
      end
    end
    lock = 1'b0;
    step();
    checks++;
    if (grant !== '0 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL lock_release grant=%b to=%b required 0000/1", grant, timeout);
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      done = ($urandom_range(0, 6) == 0);
      rst  = ($urandom_range(0, 149) == 0);
`ifdef RR_ARB_LOCK_EN
      if ($urandom_range(0, 9) == 0) lock = ~lock;
`endif
      step();
      checks++;
      if (grant !== e_grant || grant_valid !== e_valid || grant_id !== e_id || timeout !== e_to) begin
        failures++;
        $display("FAIL random c=%0d grant=%b/%b valid=%b/%b id=%0d/%0d to=%b/%b (got/required)",
                 c, grant, e_grant, grant_valid, e_valid, grant_id, e_id, timeout, e_to);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_rotation();
    test_timeout();
    test_limit_coincide();
    test_reset_mid_burst();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- N-requester round-robin arbiter that shares one downstream resource (bus or datapath port) between requesters.
- Grants are registered and one-hot. A grant is held for a burst until the owner drops req, the resource signals done, or a maximum-hold limit forces preemption.
- Exactly one idle gap cycle is inserted between owners.
- Sits between requesting masters and the shared resource; extends the 2-port arbiter FSM to N ports with burst hold and fairness.

Parameters:
- N, 4, number of requesters; legal 2..16.
- MAX_HOLD, 16, max consecutive cycles one grant may be held; legal >= 2.
- ID_W, $clog2(N), width of grant_id (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N  per-requester request level; held high for the whole burst.
- done  input  1  resource reports current owner's transaction complete; ignored unless grant_valid=1.
- grant  output  N  one-hot grant, registered; all zero when no owner.
- grant_valid  output  1  high when grant != 0.
- grant_id  output  ID_W  binary index of owner; holds last owner when grant_valid=0.
- timeout  output  1  single-cycle pulse when a grant was revoked by MAX_HOLD.

Behaviour:
- Reset values: grant=0, grant_valid=0, grant_id=0, timeout=0, rr pointer ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-burst: grant drops at the reset edge, no timeout pulse, ptr returns to 0.
- States: IDLE, BUSY, GAP.
- IDLE/GAP arbitration:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... wrapping mod N.
  - At the next edge: grant is one-hot for that bit, grant_id = index, hold_cnt=1, state=BUSY.
  - If req == 0: state=IDLE, grant=0.
  - Latency from req rising in IDLE to grant: 1 cycle.
- BUSY, evaluated each cycle with owner o:
  - Release conditions are req[o]==0, done==1, or hold_cnt==MAX_HOLD.
  - If any condition holds: at the next edge grant=0, state=GAP, ptr=(o+1) mod N.
  - Otherwise hold_cnt increments and grant is unchanged.
  - Max grant-high cycles per burst = MAX_HOLD.
- timeout:
  - Asserted in the GAP cycle only when release was caused solely by hold_cnt==MAX_HOLD (req[o]=1 and done=0).
  - If done, or req[o] dropping, coincides with hold_cnt==MAX_HOLD, it is a normal release and timeout=0.
- GAP: lasts exactly one cycle with grant=0, then arbitrates as IDLE. A back-to-back handoff therefore shows grant low for exactly 1 cycle.
- Fairness: an owner just released is lowest priority at the next arbitration. With all N requesting continuously, grants rotate 0,1,...,N-1,0.
- Request changes:
  - Changes on non-owner req bits during BUSY have no effect until the next arbitration.
  - A requester that drops req before being granted is simply not selected.
- grant and grant_valid change only on clock edges. Combinational paths exist only from req/done to next-state logic, never to outputs.

Optional Feature:
- Macro RR_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit, after done).
  - While grant_valid=1 and lock=1, the MAX_HOLD preemption is suppressed. hold_cnt saturates at MAX_HOLD and the owner keeps the grant until req[o]=0 or done=1.
  - timeout never asserts while lock=1.
  - Deasserting lock with hold_cnt==MAX_HOLD releases at the next edge with timeout=1.
- When undefined: no lock port; behaviour exactly as above.

Test Plan:
- Reset, then req=4'b0100 held, done=0 -> grant=4'b0100 one cycle after req, grant_id=2. Drop req[2] after 3 grant cycles -> grant=0 next cycle, ptr=3.
- N=4, req=4'b1111 constant, done pulsed every 3rd grant cycle -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 with each grant high 3 cycles.
- MAX_HOLD=8, req=4'b0011 held, done=0 -> grant 0001 high exactly 8 cycles, then timeout=1 for one cycle with grant=0, then grant=0010.
- In BUSY at hold_cnt==MAX_HOLD, drive done=1 in the same cycle -> release, timeout=0.
- Assert rst during a burst (grant=0100) -> grant=0, timeout=0 after edge. req=4'b1111 afterwards -> first grant=0001.
- RR_ARB_LOCK_EN defined, MAX_HOLD=4, lock=1, req[1] held 10 cycles -> grant 0010 stays 10 cycles, no timeout. Drop lock at cycle 6 instead -> release next edge, timeout=1.
